// File: rtl/otter_cu_fsm.sv
// ----------------------------------------------------------------------------
// otter_cu_fsm
// Multicycle control FSM for the OTTER RV32I core. It steps each instruction
// through fetch, execute, an optional load writeback and an optional
// interrupt entry. It drives only the enables (PC, register file, memory
// ports and CSR file). Mux and ALU selects come from the combinational
// decoder.
//
// Parameter
//   MEM_HANDSHAKE : 1 = memory phases wait on MEM_READY,
//                   0 = MEM_READY is ignored and treated as always 1
//
// Ports
//   CLK        in  system clock
//   RST        in  synchronous active-high reset
//   CU_OPCODE  in  IR[6:0]
//   CU_FUNC3   in  IR[14:12]
//   INTR       in  external interrupt request (level; the rising edge is the event)
//   CSR_MIE    in  mstatus.MIE
//   MEM_READY  in  memory has completed the current fetch/load/store
//   PC_WRITE   out load the PC
//   REG_WRITE  out register file write enable
//   MEM_RDEN1  out instruction-port read enable
//   MEM_RDEN2  out data-port read enable
//   MEM_WE2    out data-port write enable
//   CSR_WE     out CSR file write enable
//   INT_TAKEN  out interrupt entry strobe
//   MRET_EXEC  out mret executing
//   STATE      out 0 FETCH, 1 EXEC, 2 WB, 3 INTR
// ----------------------------------------------------------------------------
module otter_cu_fsm #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] CU_OPCODE,
    input  logic [2:0] CU_FUNC3,
    input  logic       INTR,
    input  logic       CSR_MIE,
    input  logic       MEM_READY,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       CSR_WE,
    output logic       INT_TAKEN,
    output logic       MRET_EXEC,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB    = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t state_reg, state_next;
    logic   intr_q_reg;
    logic   int_pend_reg, int_pend_next;

    logic   mem_ready;
    logic   int_edge;
    logic   take_int;
    logic   complete;

    assign mem_ready = MEM_HANDSHAKE ? MEM_READY : 1'b1;
    assign int_edge  = INTR & ~intr_q_reg;
    // The edge is also counted in the cycle it occurs, so an interrupt that
    // rises during a completion cycle is taken right away.
    assign take_int  = (int_pend_reg | int_edge) & CSR_MIE;

    // A new edge must win over the clear. If the request rose while the core
    // was entering a handler, it stays pending for the next boundary.
    always_comb begin
        int_pend_next = int_pend_reg;
        if (state_reg == ST_INTR) begin
            int_pend_next = 1'b0;
        end
        if (int_edge) begin
            int_pend_next = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_FETCH;
            intr_q_reg   <= 1'b0;
            int_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            intr_q_reg   <= INTR;
            int_pend_reg <= int_pend_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        complete   = 1'b0;
        PC_WRITE   = 1'b0;
        REG_WRITE  = 1'b0;
        MEM_RDEN1  = 1'b0;
        MEM_RDEN2  = 1'b0;
        MEM_WE2    = 1'b0;
        CSR_WE     = 1'b0;
        INT_TAKEN  = 1'b0;
        MRET_EXEC  = 1'b0;

        unique case (state_reg)
            ST_FETCH: begin
                MEM_RDEN1 = 1'b1;
                if (mem_ready) begin
                    state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (CU_OPCODE)
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: begin
                        REG_WRITE = 1'b1;
                        PC_WRITE  = 1'b1;
                        complete  = 1'b1;
                    end
                    OP_BRANCH: begin
                        PC_WRITE = 1'b1;
                        complete = 1'b1;
                    end
                    OP_LOAD: begin
                        // The address is issued here. The data is collected in WB.
                        MEM_RDEN2  = 1'b1;
                        state_next = ST_WB;
                    end
                    OP_STORE: begin
                        MEM_WE2 = 1'b1;
                        if (mem_ready) begin
                            PC_WRITE = 1'b1;
                            complete = 1'b1;
                        end
                    end
                    OP_SYSTEM: begin
                        PC_WRITE = 1'b1;
                        complete = 1'b1;
                        if (CU_FUNC3 == 3'b000) begin
                            MRET_EXEC = 1'b1;
                        end else if (CU_FUNC3 != 3'b100) begin
                            CSR_WE    = 1'b1;
                            REG_WRITE = 1'b1;
                        end
                    end
                    default: begin
                        // Unknown opcodes retire as a NOP so the core keeps running.
                        PC_WRITE = 1'b1;
                        complete = 1'b1;
                    end
                endcase
            end

            ST_WB: begin
                if (mem_ready) begin
                    REG_WRITE = 1'b1;
                    PC_WRITE  = 1'b1;
                    complete  = 1'b1;
                end
            end

            ST_INTR: begin
                INT_TAKEN  = 1'b1;
                PC_WRITE   = 1'b1;
                state_next = ST_FETCH;
            end

            default: begin
                state_next = ST_FETCH;
            end
        endcase

        // Instruction boundary: the only point where an interrupt can enter.
        if (complete) begin
            state_next = take_int ? ST_INTR : ST_FETCH;
        end

        // Reset forces every enable low in the same cycle. This includes a
        // store that is still waiting on memory.
        if (RST) begin
            PC_WRITE  = 1'b0;
            REG_WRITE = 1'b0;
            MEM_RDEN1 = 1'b0;
            MEM_RDEN2 = 1'b0;
            MEM_WE2   = 1'b0;
            CSR_WE    = 1'b0;
            INT_TAKEN = 1'b0;
            MRET_EXEC = 1'b0;
        end
    end

    assign STATE = RST ? 2'd0 : state_reg;

endmodule
